oled_border_fx: RTL and testbench
=================================

# oled_border_fx

Parametrised border overlay for the RGB565 OLED pixel pipeline. It sits between the scene generator and the OLED driver. It takes a pixel index and the scene pixel for that index, and returns either the scene pixel or a border colour. Border geometry is set by parameters, and the border can be static, blinking, or a segment that chases around the screen edge, all stepped on frame boundaries.

## Interface
Parameters:
- `WIDTH`, 96, screen width in pixels
- `HEIGHT`, 64, screen height in pixels
- `THICK`, 3, border thickness in pixels, applied on all four sides; legal range 1..min(WIDTH,HEIGHT)/2
- `BLINK_FRAMES`, 30, frames per blink half-period; must be ≥1
- `CHASE_LEN`, 24, lit chase segment length in perimeter steps; must be ≤ P
- `CHASE_STEP`, 2, perimeter steps the chase segment advances per frame; must be < P

Ports:
- `clock` in 1, pixel clock; one clock domain, reset is synchronous and active-low
- `reset_n` in 1, synchronous active-low reset
- `frame_begin` in 1, single-cycle pulse once per frame
- `pixel_index` in 13, linear index = y*WIDTH + x
- `pixel_in` in 16, scene RGB565 pixel for `pixel_index`
- `mode` in 2, border mode: 0 off, 1 static, 2 blink, 3 chase
- `colour_sel` in 2, border colour: 0 white, 1 red, 2 blue, 3 green
- `pixel_out` out 16, final RGB565 pixel
- `in_border` out 1, set when the output pixel lies in the border region, in any mode other than off

## Operation
Stage 1 (registered):
- x = pixel_index mod WIDTH, y = pixel_index / WIDTH
- `pixel_in`, `mode`, and `colour_sel` are delayed alongside x and y.

Border region:
- A pixel is in the border when x<THICK, x≥WIDTH−THICK, y<THICK, or y≥HEIGHT−THICK.
- Indices ≥ WIDTH*HEIGHT produce `pixel_out` = `pixel_in` (delayed) and `in_border` = 0.

Perimeter position p, with P = 2*(WIDTH+HEIGHT). Top/bottom take precedence over sides:
- top band: p = x
- right band: p = WIDTH + y
- bottom band: p = WIDTH + HEIGHT + (WIDTH−1−x)
- left band: p = 2*WIDTH + HEIGHT + (HEIGHT−1−y)

Modes, for pixels in the border:
- off: pass the scene pixel through.
- static: output the selected colour.
- blink: output the colour when `blink_on`=1, otherwise pass the scene pixel through.
- chase: d = (p − chase_pos) mod P. If d < CHASE_LEN, output the full colour. Otherwise output the half colour (each R/G/B field shifted right by 1).

Frame state, updated only on `frame_begin`:
- `frame_cnt` counts 0..BLINK_FRAMES−1. On wrap, `blink_on` toggles.
- `chase_pos` advances by CHASE_STEP modulo P, using subtract-on-overflow with no multiply.
- Both counters always run, independent of `mode`.

Mode change (stage-1 `mode` differs from its previous value):
- On entry to blink: `blink_on` is forced to 1 and `frame_cnt` to 0. This takes priority over a same-cycle `frame_begin`.
- On entry to chase: `chase_pos` is forced to 0.

Width rules:
- x, y, and p are sized with $clog2.
- The modulo in d is computed as (p + P − chase_pos), with one conditional subtract of P.

## Timing
- Latency: `pixel_out` and `in_border` correspond to the `pixel_index` and `pixel_in` presented 2 cycles earlier. Throughput is one pixel per cycle with no stalls.
- Mode and colour are sampled with the pixel, so a change takes effect exactly on the pixel where it was presented.
- Frame state updates take effect on the cycle after `frame_begin`.
- Reset values: `pixel_out`=0, `in_border`=0, `frame_cnt`=0, `blink_on`=1, `chase_pos`=0, pipeline registers 0.
- Reset asserted mid-frame clears all state on the next edge. The output is valid again 2 cycles after `reset_n` rises.

## Structure
- Shared package `oled_pkg` holds:
  - RGB565 constants COL_WHITE=16'hFFFF, COL_RED=16'hF800, COL_BLUE=16'h001F, COL_GREEN=16'h07E0
  - the mode enum (MODE_OFF, MODE_STATIC, MODE_BLINK, MODE_CHASE)
  - the half-intensity function
- Sub-module `oled_pixel_coord` (index → registered x, y, plus a `valid` flag for in-range indices) is reusable by other overlays.

## Test plan
- Static, red, defaults: index 0 → `pixel_out`=16'hF800 and `in_border`=1 two cycles later. Index 3*96+3=291 with `pixel_in`=16'h1234 → 16'h1234 and `in_border`=0. Index 95 → F800. Index 63*96 → F800.
- Blink, BLINK_FRAMES=2, white: border is FFFF. After 2 `frame_begin` pulses the border passes the scene pixel through. After 4 pulses it is FFFF again. Re-entering blink mid-count restores FFFF immediately.
- Chase, blue, CHASE_LEN=24, CHASE_STEP=2:
  - At reset, x=0..23 on row 0 → 001F, and x=24 → 000F.
  - After 1 `frame_begin`, x=0..1 → 000F and x=2..25 → 001F.
- Chase wrap: after 160 pulses (P=320), `chase_pos` is back to 0 and the pattern equals the reset pattern. Lit-segment pixels near the end of the left band (p≥300) light correctly across the wrap.
- Out-of-range index 6144 with any mode → pass-through with `in_border`=0. Mode off → every pixel is a pass-through with `in_border`=0.
- Reset asserted mid-frame in chase mode with `chase_pos`=40 → `chase_pos`=0 and `pixel_out`=0 while reset is held. Valid output resumes 2 cycles after release.

Source files
------------

// File: rtl/oled_pkg.sv
// oled_pkg: shared RGB565 colours, border mode encoding and colour helpers.
// Revision 1.0 - initial release.
`default_nettype none

package oled_pkg;

  localparam logic [15:0] COL_WHITE = 16'hFFFF;
  localparam logic [15:0] COL_RED   = 16'hF800;
  localparam logic [15:0] COL_BLUE  = 16'h001F;
  localparam logic [15:0] COL_GREEN = 16'h07E0;

  typedef enum logic [1:0] {
    MODE_OFF    = 2'd0,
    MODE_STATIC = 2'd1,
    MODE_BLINK  = 2'd2,
    MODE_CHASE  = 2'd3
  } mode_t;

  // Shift the whole word right once, then clear the bits that leaked in from
  // the neighbouring field (top bit of each of R, G and B).
  function automatic logic [15:0] half_colour(input logic [15:0] c);
    return (c >> 1) & 16'h7BEF;
  endfunction

  function automatic logic [15:0] colour_of(input logic [1:0] sel);
    logic [15:0] c;
    case (sel)
      2'd0:    c = COL_WHITE;
      2'd1:    c = COL_RED;
      2'd2:    c = COL_BLUE;
      default: c = COL_GREEN;
    endcase
    return c;
  endfunction

endpackage

`default_nettype wire

// File: rtl/oled_pixel_coord.sv
// oled_pixel_coord: registers the (x, y) of a linear pixel index plus an in-range flag.
// Revision 1.0 - initial release.
`default_nettype none

module oled_pixel_coord #(
  parameter int WIDTH  = 96,
  parameter int HEIGHT = 64,
  parameter int XW     = $clog2(WIDTH),
  parameter int YW     = $clog2(HEIGHT)
) (
  input  logic          clock,
  input  logic          reset_n,
  input  logic [12:0]   pixel_index,
  output logic [XW-1:0] x,
  output logic [YW-1:0] y,
  output logic          valid
);

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      x     <= '0;
      y     <= '0;
      valid <= 1'b0;
    end else begin
      x     <= XW'(pixel_index % 13'(WIDTH));
      y     <= YW'(pixel_index / 13'(WIDTH));
      valid <= (pixel_index < 13'(WIDTH * HEIGHT));
    end
  end

endmodule

`default_nettype wire

// File: rtl/oled_border_fx.sv
// oled_border_fx: two-stage RGB565 border overlay with static, blink and chase effects.
// Revision 1.0 - initial release.
`default_nettype none

module oled_border_fx
  import oled_pkg::*;
#(
  parameter int WIDTH        = 96,
  parameter int HEIGHT       = 64,
  parameter int THICK        = 3,
  parameter int BLINK_FRAMES = 30,
  parameter int CHASE_LEN    = 24,
  parameter int CHASE_STEP   = 2
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        frame_begin,
  input  logic [12:0] pixel_index,
  input  logic [15:0] pixel_in,
  input  logic [1:0]  mode,
  input  logic [1:0]  colour_sel,
  output logic [15:0] pixel_out,
  output logic        in_border
);

  localparam int P  = 2 * (WIDTH + HEIGHT);
  localparam int XW = $clog2(WIDTH);
  localparam int YW = $clog2(HEIGHT);
  localparam int PW = $clog2(P);
  localparam int FW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

  logic [XW-1:0] x;
  logic [YW-1:0] y;
  logic          valid;
  logic [15:0]   pixel_d;
  mode_t         mode_d;
  mode_t         mode_prev;
  logic [1:0]    colour_d;

  logic [FW-1:0] frame_cnt;
  logic          blink_on;
  logic [PW-1:0] chase_pos;

  logic          enter_blink;
  logic          enter_chase;
  logic [PW:0]   chase_sum;
  logic [PW-1:0] chase_next;

  logic          border;
  logic [PW-1:0] p;
  logic [PW-1:0] pos_eff;
  logic          blink_eff;
  logic [PW:0]   d_raw;
  logic [PW:0]   d;
  logic [15:0]   colour;
  logic [15:0]   out_next;
  logic          border_next;

  oled_pixel_coord #(
    .WIDTH  (WIDTH),
    .HEIGHT (HEIGHT),
    .XW     (XW),
    .YW     (YW)
  ) u_coord (
    .clock       (clock),
    .reset_n     (reset_n),
    .pixel_index (pixel_index),
    .x           (x),
    .y           (y),
    .valid       (valid)
  );

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      pixel_d   <= '0;
      mode_d    <= MODE_OFF;
      mode_prev <= MODE_OFF;
      colour_d  <= '0;
    end else begin
      pixel_d   <= pixel_in;
      mode_d    <= mode_t'(mode);
      mode_prev <= mode_d;
      colour_d  <= colour_sel;
    end
  end

  assign enter_blink = (mode_d == MODE_BLINK) && (mode_prev != MODE_BLINK);
  assign enter_chase = (mode_d == MODE_CHASE) && (mode_prev != MODE_CHASE);

  always_comb begin
    chase_sum  = {1'b0, chase_pos} + (PW+1)'(CHASE_STEP);
    chase_next = chase_pos;
    if (chase_sum >= (PW+1)'(P)) chase_next = PW'(chase_sum - (PW+1)'(P));
    else                         chase_next = PW'(chase_sum);
  end

  // Mode entry wins over a coincident frame pulse so the effect always starts clean.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      frame_cnt <= '0;
      blink_on  <= 1'b1;
      chase_pos <= '0;
    end else begin
      if (enter_blink) begin
        frame_cnt <= '0;
        blink_on  <= 1'b1;
      end else if (frame_begin) begin
        if (frame_cnt == FW'(BLINK_FRAMES - 1)) begin
          frame_cnt <= '0;
          blink_on  <= ~blink_on;
        end else begin
          frame_cnt <= frame_cnt + 1'b1;
        end
      end

      if (enter_chase)      chase_pos <= '0;
      else if (frame_begin) chase_pos <= chase_next;
    end
  end

  // The pixel that carries a new mode already sees the freshly entered state.
  assign pos_eff   = enter_chase ? '0 : chase_pos;
  assign blink_eff = enter_blink | blink_on;
  assign colour    = colour_of(colour_d);

  always_comb begin
    border = (x < XW'(THICK)) || (x >= XW'(WIDTH - THICK)) ||
             (y < YW'(THICK)) || (y >= YW'(HEIGHT - THICK));

    if (y < YW'(THICK))
      p = PW'(x);
    else if (y >= YW'(HEIGHT - THICK))
      p = PW'(2 * WIDTH + HEIGHT - 1) - PW'(x);
    else if (x >= XW'(WIDTH - THICK))
      p = PW'(WIDTH) + PW'(y);
    else
      p = PW'(2 * WIDTH + 2 * HEIGHT - 1) - PW'(y);

    d_raw = {1'b0, p} + (PW+1)'(P) - {1'b0, pos_eff};
    if (d_raw >= (PW+1)'(P)) d = d_raw - (PW+1)'(P);
    else                     d = d_raw;

    out_next    = pixel_d;
    border_next = 1'b0;
    if (valid && border && (mode_d != MODE_OFF)) begin
      border_next = 1'b1;
      case (mode_d)
        MODE_STATIC: out_next = colour;
        MODE_BLINK:  if (blink_eff) out_next = colour;
        MODE_CHASE:  out_next = (d < (PW+1)'(CHASE_LEN)) ? colour : half_colour(colour);
        default:     out_next = pixel_d;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      pixel_out <= '0;
      in_border <= 1'b0;
    end else begin
      pixel_out <= out_next;
      in_border <= border_next;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_oled_border_fx.sv
// tb_oled_border_fx: directed/random stimulus against a frame-level reference model.
// Revision 1.0 - initial release.
`default_nettype none

module tb_oled_border_fx;

  localparam int W  = 96;
  localparam int H  = 64;
  localparam int T  = 3;
  localparam int BF = 2;
  localparam int CL = 24;
  localparam int CS = 2;
  localparam int P  = 2 * (W + H);

  logic        clock = 1'b0;
  logic        reset_n;
  logic        frame_begin;
  logic [12:0] pixel_index;
  logic [15:0] pixel_in;
  logic [1:0]  mode;
  logic [1:0]  colour_sel;
  logic [15:0] pixel_out;
  logic        in_border;

  oled_border_fx #(
    .WIDTH        (W),
    .HEIGHT       (H),
    .THICK        (T),
    .BLINK_FRAMES (BF),
    .CHASE_LEN    (CL),
    .CHASE_STEP   (CS)
  ) dut (
    .clock       (clock),
    .reset_n     (reset_n),
    .frame_begin (frame_begin),
    .pixel_index (pixel_index),
    .pixel_in    (pixel_in),
    .mode        (mode),
    .colour_sel  (colour_sel),
    .pixel_out   (pixel_out),
    .in_border   (in_border)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [15:0] px;
    logic        ib;
    string       tag;
  } exp_t;

  exp_t q[$];
  int   compared = 0;
  int   mismatched = 0;
  int   cols[4] = '{32'hFFFF, 32'hF800, 32'h001F, 32'h07E0};

  // Frame pulses counted since reset or since the last entry into each effect.
  int   blink_frames = 0;
  int   chase_frames = 0;
  int   prev_mode = 0;
  bit   pend_blink = 0;
  bit   pend_chase = 0;
  int   cur_mode = 0;
  int   cur_col = 0;

  task automatic model(input int idx, input logic [15:0] pin, input int m, input int col,
                       input int bfr, input int cfr, output logic ib, output logic [15:0] px);
    int x, y, p, pos, d, c, r, g, b;
    bit border;
    ib = 1'b0;
    px = pin;
    if (idx < W * H && m != 0) begin
      x = idx % W;
      y = idx / W;
      border = (x < T) || (x >= W - T) || (y < T) || (y >= H - T);
      if (border) begin
        ib = 1'b1;
        c  = cols[col];
        case (m)
          1: px = c[15:0];
          2: if (((bfr / BF) % 2) == 0) px = c[15:0];
          default: begin
            pos = (CS * cfr) % P;
            if (y < T)           p = x;
            else if (y >= H - T) p = W + H + (W - 1 - x);
            else if (x >= W - T) p = W + y;
            else                 p = 2 * W + H + (H - 1 - y);
            d = ((p - pos) % P + P) % P;
            if (d < CL) px = c[15:0];
            else begin
              r = (c >> 11) & 31;
              g = (c >> 5) & 63;
              b = c & 31;
              c = ((r / 2) << 11) | ((g / 2) << 5) | (b / 2);
              px = c[15:0];
            end
          end
        endcase
      end
    end
  endtask

  task automatic step(input int idx, input logic [15:0] pin, input int m, input int col,
                      input logic fb, input logic rst, input string tag);
    exp_t e;
    exp_t chk;
    bit eb, ec;
    reset_n     = ~rst;
    frame_begin = fb;
    pixel_index = idx[12:0];
    pixel_in    = pin;
    mode        = m[1:0];
    colour_sel  = col[1:0];
    e.tag = tag;
    if (rst) begin
      blink_frames = 0;
      chase_frames = 0;
      prev_mode    = 0;
      pend_blink   = 0;
      pend_chase   = 0;
      e.px = 16'h0000;
      e.ib = 1'b0;
    end else begin
      if (fb) begin
        blink_frames++;
        chase_frames++;
      end
      if (pend_blink) blink_frames = 0;
      if (pend_chase) chase_frames = 0;
      eb = (m == 2) && (prev_mode != 2);
      ec = (m == 3) && (prev_mode != 3);
      model(idx, pin, m, col, eb ? 0 : blink_frames, ec ? 0 : chase_frames, e.ib, e.px);
      pend_blink = eb;
      pend_chase = ec;
      prev_mode  = m;
    end
    q.push_back(e);
    @(posedge clock);
    #1;
    if (q.size() > 1) begin
      chk = q.pop_front();
      if (rst) begin
        chk.px  = 16'h0000;
        chk.ib  = 1'b0;
        chk.tag = "reset_held";
      end
      compared++;
      assert (pixel_out === chk.px) else begin
        mismatched++;
        $error("FAIL %s pixel_out observed=%h expected=%h", chk.tag, pixel_out, chk.px);
      end
      compared++;
      assert (in_border === chk.ib) else begin
        mismatched++;
        $error("FAIL %s in_border observed=%b expected=%b", chk.tag, in_border, chk.ib);
      end
    end
  endtask

  function automatic int rand_idx();
    int s;
    s = $urandom_range(0, 5);
    case (s)
      0:       return $urandom_range(0, T * W - 1);
      1:       return $urandom_range((H - T) * W, H * W - 1);
      2:       return $urandom_range(0, H - 1) * W + $urandom_range(0, T - 1);
      3:       return $urandom_range(0, H - 1) * W + $urandom_range(W - T, W - 1);
      default: return $urandom_range(0, W * H - 1);
    endcase
  endfunction

  task automatic px(input int idx, input string tag);
    step(idx, 16'($urandom), cur_mode, cur_col, 1'b0, 1'b0, tag);
  endtask

  task automatic pulses(input int n);
    for (int i = 0; i < n; i++)
      step(rand_idx(), 16'($urandom), cur_mode, cur_col, 1'b1, 1'b0, "frame_pulse");
  endtask

  task automatic rand_pixels(input int n, input string tag);
    for (int i = 0; i < n; i++) px(rand_idx(), tag);
  endtask

  initial begin
    reset_n = 1'b0;
    frame_begin = 1'b0;
    pixel_index = '0;
    pixel_in = '0;
    mode = '0;
    colour_sel = '0;

    repeat (3) step(0, 16'($urandom), 0, 0, 1'b0, 1'b1, "reset");

    // Static red
    cur_mode = 1; cur_col = 1;
    px(0, "static_idx0");
    step(3 * 96 + 3, 16'h1234, 1, 1, 1'b0, 1'b0, "static_inner");
    px(95, "static_idx95");
    px(63 * 96, "static_bottom_left");
    for (int i = 0; i < 40; i++)
      step(rand_idx(), 16'($urandom), 1, $urandom_range(0, 3), 1'b0, 1'b0, "static_rand");

    // Blink white
    cur_mode = 2; cur_col = 0;
    rand_pixels(10, "blink_on_initial");
    pulses(2);
    rand_pixels(10, "blink_off");
    pulses(2);
    rand_pixels(10, "blink_on_again");
    pulses(3);
    rand_pixels(8, "blink_mid_count");
    cur_mode = 1;
    rand_pixels(3, "blink_to_static");
    cur_mode = 2;
    rand_pixels(8, "blink_reentry");

    // Chase blue
    cur_mode = 3; cur_col = 2;
    px(3000, "chase_entry");
    for (int x = 0; x <= 24; x++) px(x, "chase_reset_row0");
    pulses(1);
    for (int x = 0; x <= 25; x++) px(x, "chase_step1_row0");
    rand_pixels(30, "chase_rand");
    cur_mode = 1;
    px(0, "chase_leave");
    cur_mode = 3;
    px(3000, "chase_reenter");
    pulses(160);
    for (int x = 0; x <= 24; x++) px(x, "chase_wrap_row0");
    pulses(150);
    for (int y = H - 1; y >= T; y -= 3) px(y * W + $urandom_range(0, T - 1), "chase_left_p300");
    for (int x = 0; x <= 10; x++) px(x, "chase_row0_p300");
    pulses(5);
    for (int y = H - 1; y >= T; y -= 2) px(y * W, "chase_left_wrap");
    for (int x = 0; x <= 15; x++) px(x, "chase_row0_wrap");
    rand_pixels(30, "chase_rand2");

    // Out-of-range and mode off
    for (int m = 0; m < 4; m++)
      step(6144, 16'($urandom), m, $urandom_range(0, 3), 1'b0, 1'b0, "out_of_range");
    step(8191, 16'($urandom), 1, 1, 1'b0, 1'b0, "out_of_range_max");
    cur_mode = 0;
    rand_pixels(30, "mode_off");

    // Reset mid-frame during chase
    cur_mode = 3; cur_col = 3;
    px(3000, "chase2_entry");
    pulses(20);
    for (int x = 38; x <= 64; x += 2) px(x, "chase_pos40");
    repeat (3) step(rand_idx(), 16'($urandom), 3, 3, 1'b0, 1'b1, "reset_mid");
    for (int x = 0; x <= 25; x++) px(x, "after_reset_row0");
    rand_pixels(10, "after_reset_rand");

    px(3000, "flush");
    px(3000, "flush");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

`default_nettype wire
